// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, debouncer and press/auto-repeat
// pulse generator per channel, feeding the CPU's PIO inputs.
module button_conditioner #(
  parameter int unsigned      N_BTN         = 3,
  parameter bit               ACTIVE_LOW    = 1'b1,
  parameter int unsigned      DEB_CYCLES    = 500000,
  parameter int unsigned      REPEAT_DELAY  = 25000000,
  parameter int unsigned      REPEAT_PERIOD = 10000000,
  parameter logic [N_BTN-1:0] REPEAT_MASK   = 3'b011
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic             any_pulse
);

  localparam int unsigned CNT_W = (DEB_CYCLES < 1) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam int unsigned T_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TMR_W = $clog2(T_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    HELD   = 2'd3
  } state_t;

  logic [N_BTN-1:0] raw_norm;
  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [N_BTN-1:0] stable;
  logic [N_BTN-1:0] fire_c;

  // Normalize polarity before the synchronizer so its reset value means "unpressed".
  assign raw_norm = ACTIVE_LOW ? ~btn_raw : btn_raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_norm;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < int'(N_BTN); i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic             stb;
    state_t           state;
    logic [TMR_W-1:0] timer;
    logic             deb_done;
    logic             rise;
    logic             fall;
    logic             delay_done;
    logic             period_done;

    assign deb_done    = (sync2[i] != stb) && (cnt == CNT_W'(DEB_CYCLES - 1));
    assign rise        = deb_done && !stb;
    assign fall        = deb_done && stb;
    assign delay_done  = (timer == TMR_W'(REPEAT_DELAY - 1));
    assign period_done = (timer == TMR_W'(REPEAT_PERIOD - 1));

    // Release suppresses any repeat that would fire in the same cycle.
    assign fire_c[i] = !fall && (((state == IDLE) && rise) ||
                                 ((state == DELAY) && delay_done) ||
                                 ((state == REPEAT) && period_done));
    assign stable[i] = stb;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stb <= 1'b0;
        cnt <= '0;
      end else if (sync2[i] == stb) begin
        cnt <= '0;
      end else if (deb_done) begin
        stb <= ~stb;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state <= IDLE;
        timer <= '0;
      end else if (fall) begin
        state <= IDLE;
        timer <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              timer <= '0;
              state <= REPEAT_MASK[i] ? DELAY : HELD;
            end
          end
          DELAY: begin
            if (delay_done) begin
              timer <= '0;
              state <= REPEAT;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
          REPEAT: begin
            if (period_done) begin
              timer <= '0;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
          HELD: begin
            timer <= '0;
          end
          default: begin
            state <= IDLE;
            timer <= '0;
          end
        endcase
      end
    end
  end

  assign btn_level = stable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_pulse <= '0;
      any_pulse <= 1'b0;
    end else begin
      btn_pulse <= fire_c;
      any_pulse <= |fire_c;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: reset, bounce, auto-repeat,
// non-repeating channel, release priority and reset during a held press.
module tb_button_conditioner;

  localparam int unsigned N   = 3;
  localparam int unsigned DEB = 4;
  localparam int unsigned RD  = 20;
  localparam int unsigned RP  = 8;

  logic         clk;
  logic         reset;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_pulse;
  logic         any_pulse;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int q0[$];
  int q1[$];
  int q2[$];

  button_conditioner #(
    .N_BTN        (N),
    .ACTIVE_LOW   (1'b1),
    .DEB_CYCLES   (DEB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP),
    .REPEAT_MASK  (3'b011)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .any_pulse(any_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Record the edge number of every pulse, and cross-check any_pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (btn_pulse[0]) q0.push_back(cyc);
      if (btn_pulse[1]) q1.push_back(cyc);
      if (btn_pulse[2]) q2.push_back(cyc);
      if (btn_pulse != '0 || any_pulse)
        check("any_pulse", 32'(any_pulse), 32'(|btn_pulse));
    end
  end

  task automatic to_edge(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic to_post(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t, tf, t0, tr, ta, tp, t1, p, tr2;
    int exp_rep[6];
    int exp_rp[3];
    exp_rep = '{0, 20, 28, 36, 44, 52};
    exp_rp  = '{0, 20, 28};

    // Reset with buttons released
    reset   = 1'b1;
    btn_raw = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    check("rst_level", 32'(btn_level), 32'(0));
    check("rst_pulse", 32'(btn_pulse), 32'(0));
    check("rst_any",   32'(any_pulse), 32'(0));
    reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("idle_pulses", 32'(q0.size() + q1.size() + q2.size()), 32'(0));

    // Bounce on ch0, then hold: one press pulse followed by auto-repeat
    t = cyc;
    for (int k = 1; k <= 10; k++) begin
      to_edge(t + 2 * (k - 1));
      btn_raw[0] = ((k % 2) == 0);
    end
    to_edge(t + 20);
    btn_raw[0] = 1'b0;
    tf = cyc;
    t0 = tf + int'(DEB) + 2;
    to_edge(t0 - 1);
    check("bnc_lvl_pre",  32'(btn_level[0]), 32'(0));
    check("bnc_pulsecnt", 32'(q0.size()), 32'(0));
    to_edge(t0);
    check("bnc_lvl", 32'(btn_level[0]), 32'(1));
    // Release lands exactly on a repeat slot (t0+60): no pulse there
    to_edge(tf + 60);
    btn_raw[0] = 1'b1;
    tr = cyc;
    to_edge(tr + 5);
    check("rel_lvl_pre", 32'(btn_level[0]), 32'(1));
    to_edge(tr + 6);
    check("rel_lvl", 32'(btn_level[0]), 32'(0));
    to_edge(tr + 15);
    check("rep_count", 32'(q0.size()), 32'(6));
    for (int k = 0; k < 6 && k < q0.size(); k++)
      check("rep_edge", 32'(q0[k]), 32'(t0 + exp_rep[k]));

    // Non-repeating ch2 held for 60 cycles
    to_edge(cyc + 5);
    ta = cyc;
    btn_raw[2] = 1'b0;
    tp = ta + int'(DEB) + 2;
    for (int k = 0; k < 6; k++) begin
      to_edge(tp + 10 * k);
      check("held_lvl2", 32'(btn_level[2]), 32'(1));
    end
    to_edge(ta + 60);
    btn_raw[2] = 1'b1;
    to_edge(ta + 70);
    check("norep_count", 32'(q2.size()), 32'(1));
    if (q2.size() > 0) check("norep_edge", 32'(q2[0]), 32'(tp));
    check("norep_lvl_off", 32'(btn_level[2]), 32'(0));

    // Release priority on ch1: stable fall coincides with timer == RP-1
    to_edge(cyc + 5);
    ta = cyc;
    btn_raw[1] = 1'b0;
    t1 = ta + int'(DEB) + 2;
    to_edge(t1 + 30);
    btn_raw[1] = 1'b1;
    to_edge(t1 + 45);
    check("relpri_count", 32'(q1.size()), 32'(3));
    for (int k = 0; k < 3 && k < q1.size(); k++)
      check("relpri_edge", 32'(q1[k]), 32'(t1 + exp_rp[k]));
    check("relpri_lvl", 32'(btn_level[1]), 32'(0));
    q1.delete();

    // Fresh press from IDLE, reset asserted while a repeat pulse is high
    to_edge(cyc + 5);
    ta = cyc;
    btn_raw[1] = 1'b0;
    p = ta + int'(DEB) + 2;
    to_post(p + 28);
    check("mid_pulse_hi", 32'(btn_pulse[1]), 32'(1));
    check("mid_q_count",  32'(q1.size()), 32'(2));
    if (q1.size() > 1) check("mid_first_rep", 32'(q1[1]), 32'(p + 20));
    reset = 1'b1;
    #1;
    check("mid_rst_pulse", 32'(btn_pulse), 32'(0));
    check("mid_rst_any",   32'(any_pulse), 32'(0));
    check("mid_rst_level", 32'(btn_level), 32'(0));
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    tr2 = cyc;
    q1.delete();
    to_edge(tr2 + 30);
    check("post_rst_count", 32'(q1.size()), 32'(2));
    if (q1.size() > 0) check("post_rst_press", 32'(q1[0]), 32'(tr2 + 6));
    if (q1.size() > 1) check("post_rst_rep",   32'(q1[1]), 32'(tr2 + 26));
    btn_raw[1] = 1'b1;
    to_edge(cyc + 10);
    check("final_level", 32'(btn_level), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
